// File: rtl/adc_scan_controller.sv
// Round-robin scan controller for a serial ADC behind an external analog mux.
// Each frame configures the next channel while shifting out the previous conversion.
module adc_scan_controller #(
  parameter int unsigned NUM_CH      = 13,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned SCK_DIV     = 250,
  parameter int unsigned CONV_CYCLES = 80
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       continuous,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic                       ADC_SDO,
  output logic                       ADC_CONVST,
  output logic                       ADC_SCK,
  output logic                       ADC_SDI,
  output logic [2:0]                 MUX_CONTROL,
  output logic                       busy,
  output logic                       sample_valid,
  output logic [3:0]                 sample_ch,
  output logic [DATA_W-1:0]          sample_data,
  output logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic                       scan_done
);

  localparam int unsigned CNT_MAX = (CONV_CYCLES > SCK_DIV) ? CONV_CYCLES : SCK_DIV;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {StIdle, StConvst, StConvWait, StShift, StGap} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BIT_W-1:0]    bit_q;
  logic [DATA_W-1:0]   rx_q;
  logic [DATA_W-1:0]   sdi_sr_q;
  logic [NUM_CH-1:0]   mask_q;
  logic                cont_q;
  logic [3:0]          cfg_ch_q;
  logic                cfg_valid_q;
  logic [3:0]          rd_ch_q;
  logic                rd_valid_q;
  logic                last_q;
  logic                stop_q;

  // Returns {found, index} of the lowest set mask bit at or above lo.
  function automatic logic [4:0] find_next(input logic [NUM_CH-1:0] mask, input int lo);
    logic [4:0] r;
    r = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (mask[i] && i >= lo) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  function automatic logic [5:0] cfg_word(input logic [3:0] ch);
    return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
  endfunction

  logic [4:0]        nxt_in_mask;
  logic [4:0]        first_new;
  logic              cont_go;
  logic [DATA_W-1:0] sdi_word;

  assign nxt_in_mask = find_next(mask_q, int'(cfg_ch_q) + 1);
  assign first_new   = find_next(ch_enable, 0);
  assign cont_go     = cont_q & continuous & first_new[4];
  assign sdi_word    = cfg_valid_q ? (DATA_W'(cfg_word(cfg_ch_q)) << (DATA_W - 6)) : '0;

  // Set-up of the next frame, shared by scan acceptance and the GAP hand-off.
  logic [NUM_CH-1:0] nf_mask;
  logic [3:0]        nf_cfg_ch;
  logic              nf_cfg_valid;
  logic              nf_rd_valid;
  logic              nf_last;
  logic              nf_stop;

  always_comb begin
    nf_mask      = mask_q;
    nf_cfg_ch    = cfg_ch_q;
    nf_cfg_valid = 1'b1;
    nf_rd_valid  = cfg_valid_q;
    nf_last      = 1'b0;
    nf_stop      = 1'b0;
    if (state_q == StIdle) begin
      nf_mask     = ch_enable;
      nf_cfg_ch   = first_new[3:0];
      nf_rd_valid = 1'b0;
    end else if (nxt_in_mask[4]) begin
      nf_cfg_ch = nxt_in_mask[3:0];
    end else begin
      // This frame reads the scan's last channel; decide on the next scan now.
      nf_last = 1'b1;
      if (cont_go) begin
        nf_mask   = ch_enable;
        nf_cfg_ch = first_new[3:0];
      end else begin
        nf_cfg_valid = 1'b0;
        nf_stop      = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      rx_q         <= '0;
      sdi_sr_q     <= '0;
      mask_q       <= '0;
      cont_q       <= 1'b0;
      cfg_ch_q     <= '0;
      cfg_valid_q  <= 1'b0;
      rd_ch_q      <= '0;
      rd_valid_q   <= 1'b0;
      last_q       <= 1'b0;
      stop_q       <= 1'b0;
      ADC_CONVST   <= 1'b0;
      ADC_SCK      <= 1'b0;
      ADC_SDI      <= 1'b0;
      MUX_CONTROL  <= '0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      ch_data      <= '0;
      scan_done    <= 1'b0;
    end else begin
      ADC_CONVST   <= 1'b0;
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;
      unique case (state_q)
        StIdle, StGap: begin
          if ((state_q == StIdle && start && first_new[4]) ||
              (state_q == StGap && !stop_q)) begin
            state_q     <= StConvst;
            busy        <= 1'b1;
            ADC_CONVST  <= 1'b1;
            mask_q      <= nf_mask;
            cfg_ch_q    <= nf_cfg_ch;
            cfg_valid_q <= nf_cfg_valid;
            rd_ch_q     <= cfg_ch_q;
            rd_valid_q  <= nf_rd_valid;
            last_q      <= nf_last;
            stop_q      <= nf_stop;
            MUX_CONTROL <= nf_cfg_valid ? {2'b00, nf_cfg_ch[3]} : 3'b000;
            if (state_q == StIdle) cont_q <= continuous;
          end else if (state_q == StGap) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            MUX_CONTROL <= 3'b000;
          end
        end
        StConvst: begin
          state_q <= StConvWait;
          cnt_q   <= '0;
        end
        StConvWait: begin
          if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
            state_q  <= StShift;
            cnt_q    <= '0;
            bit_q    <= '0;
            ADC_SCK  <= 1'b0;
            ADC_SDI  <= sdi_word[DATA_W-1];
            sdi_sr_q <= sdi_word << 1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StShift: begin
          if (cnt_q == CNT_W'(SCK_DIV - 1)) begin
            cnt_q <= '0;
            if (!ADC_SCK) begin
              ADC_SCK <= 1'b1;
              rx_q    <= {rx_q[DATA_W-2:0], ADC_SDO};
            end else begin
              ADC_SCK <= 1'b0;
              if (bit_q == BIT_W'(DATA_W - 1)) begin
                state_q      <= StGap;
                sample_valid <= rd_valid_q;
                scan_done    <= rd_valid_q & last_q;
                if (rd_valid_q) begin
                  sample_ch   <= rd_ch_q;
                  sample_data <= rx_q;
                  for (int c = 0; c < int'(NUM_CH); c++) begin
                    if (rd_ch_q == 4'(c)) ch_data[c*DATA_W +: DATA_W] <= rx_q;
                  end
                end
              end else begin
                bit_q    <= bit_q + BIT_W'(1);
                ADC_SDI  <= sdi_sr_q[DATA_W-1];
                sdi_sr_q <= sdi_sr_q << 1;
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_controller.sv
// Directed bench for adc_scan_controller with a behavioural serial-ADC model and
// a queue of expected (channel, data) samples.
module tb_adc_scan_controller;

  localparam int unsigned NUM_CH = 13;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned SCK_DIV = 2;
  localparam int unsigned CONV_CYCLES = 4;
  localparam int FRAME = 2 + CONV_CYCLES + 2 * SCK_DIV * DATA_W;

  logic                      clock = 1'b0;
  logic                      rst = 1'b0;
  logic                      start = 1'b0;
  logic                      continuous = 1'b0;
  logic [NUM_CH-1:0]         ch_enable = '0;
  logic                      ADC_SDO;
  logic                      ADC_CONVST, ADC_SCK, ADC_SDI;
  logic [2:0]                MUX_CONTROL;
  logic                      busy, sample_valid, scan_done;
  logic [3:0]                sample_ch;
  logic [DATA_W-1:0]         sample_data;
  logic [NUM_CH*DATA_W-1:0]  ch_data;

  adc_scan_controller #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SCK_DIV(SCK_DIV), .CONV_CYCLES(CONV_CYCLES)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .continuous(continuous),
    .ch_enable(ch_enable), .ADC_SDO(ADC_SDO), .ADC_CONVST(ADC_CONVST),
    .ADC_SCK(ADC_SCK), .ADC_SDI(ADC_SDI), .MUX_CONTROL(MUX_CONTROL), .busy(busy),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .ch_data(ch_data), .scan_done(scan_done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] adc_val(input logic [3:0] ch);
    case (ch)
      4'd0:    return 12'hA5A;
      4'd2:    return 12'h123;
      4'd5:    return 12'h5B4;
      4'd12:   return 12'h3C7;
      default: return 12'(ch) * 12'h111;
    endcase
  endfunction

  // ADC model: result of the channel configured last frame, shifted out MSB first.
  logic [DATA_W-1:0] sdo_sr = '0;
  int                bitn = 0;
  logic [5:0]        cap = '0;
  logic              mux_snap = 1'b0;
  logic [3:0]        last_cfg = '0;
  logic [6:0]        cfg_log[$];

  assign ADC_SDO = sdo_sr[DATA_W-1];

  always @(posedge ADC_CONVST) begin
    sdo_sr = adc_val(last_cfg);
    bitn = 0;
  end

  always @(negedge ADC_SCK) sdo_sr = {sdo_sr[DATA_W-2:0], 1'b0};

  always @(posedge ADC_SCK) begin
    if (bitn == 0) mux_snap = MUX_CONTROL[0];
    if (bitn < 6) cap = {cap[4:0], ADC_SDI};
    bitn++;
    if (bitn == 6) begin
      last_cfg = {mux_snap, cap[3], cap[2], cap[4]};
      cfg_log.push_back({mux_snap, cap});
    end
  end

  // Monitor: event counters and scoreboard pops.
  logic [15:0] exp_q[$];
  int n_convst = 0, n_done = 0, n_samp = 0, n_busy = 0, glitch = 0;
  logic prev_sdi = 1'b0;

  always @(negedge clock) begin
    if (rst) begin
      if (ADC_CONVST) n_convst++;
      if (scan_done) n_done++;
      if (busy) n_busy++;
      if (ADC_SCK === 1'b1 && ADC_SDI !== prev_sdi) glitch++;
      if (sample_valid) begin
        n_samp++;
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", {sample_ch, sample_data}, 16'hFFFF);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("sample_ch", 32'(sample_ch), 32'(e[15:12]));
          chk("sample_data", 32'(sample_data), 32'(e[11:0]));
          chk("ch_data_slice", 32'(ch_data[sample_ch*DATA_W +: DATA_W]), 32'(e[11:0]));
        end
      end
    end
    prev_sdi = ADC_SDI;
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_start(input logic [NUM_CH-1:0] mask, input logic cont);
    ch_enable = mask;
    continuous = cont;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    for (t = 0; t < 3000 && busy; t++) tick();
    if (busy) chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int b_conv, b_done, b_samp, b_busy, b_log, t;

    // Reset state.
    repeat (3) tick();
    chk("rst_ctrl", {ADC_CONVST, ADC_SCK, ADC_SDI, MUX_CONTROL, busy, sample_valid,
                     scan_done, sample_ch}, 32'd0);
    chk("rst_ch_data", 32'(ch_data == '0), 32'd1);
    rst = 1'b1;
    repeat (2) tick();

    // One-shot scan of ch0 and ch2, with a stray start in the middle.
    b_conv = n_convst; b_done = n_done; b_samp = n_samp; b_busy = n_busy;
    exp_q.push_back({4'd0, 12'hA5A});
    exp_q.push_back({4'd2, 12'h123});
    do_start(13'h0005, 1'b0);
    chk("busy_after_start", 32'(busy), 32'd1);
    for (t = 0; t < 3000 && busy; t++) begin
      start = (t == 60);
      tick();
    end
    start = 1'b0;
    chk("oneshot_idle", 32'(busy), 32'd0);
    chk("oneshot_frames", 32'(n_convst - b_conv), 32'd3);
    chk("oneshot_busy_cycles", 32'(n_busy - b_busy), 32'(3 * FRAME));
    chk("oneshot_done", 32'(n_done - b_done), 32'd1);
    chk("oneshot_samples", 32'(n_samp - b_samp), 32'd2);
    chk("oneshot_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("ch_data_ch0", 32'(ch_data[0 +: DATA_W]), 32'hA5A);
    chk("ch_data_ch1", 32'(ch_data[DATA_W +: DATA_W]), 32'h000);
    chk("ch_data_ch2", 32'(ch_data[2*DATA_W +: DATA_W]), 32'h123);

    // Empty mask is ignored.
    b_conv = n_convst; b_busy = n_busy;
    do_start(13'h0000, 1'b0);
    repeat (20) tick();
    chk("empty_busy", 32'(n_busy - b_busy), 32'd0);
    chk("empty_convst", 32'(n_convst - b_conv), 32'd0);

    // Config word for ch5.
    b_log = cfg_log.size(); b_conv = n_convst;
    exp_q.push_back({4'd5, 12'h5B4});
    do_start(13'h0020, 1'b0);
    wait_idle("ch5_timeout");
    chk("ch5_frames", 32'(n_convst - b_conv), 32'd2);
    chk("ch5_cfg_log", 32'(cfg_log.size() - b_log), 32'd2);
    if (cfg_log.size() > b_log) chk("ch5_sdi_bits", 32'(cfg_log[b_log]), 32'b0111010);

    // Continuous scan of ch0 and ch12, stopped during the third scan.
    b_conv = n_convst; b_done = n_done; b_samp = n_samp; b_busy = n_busy;
    b_log = cfg_log.size();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({4'd0, 12'hA5A});
      exp_q.push_back({4'd12, 12'h3C7});
    end
    do_start(13'h1001, 1'b1);
    for (t = 0; t < 3000 && (n_done - b_done) < 2; t++) tick();
    chk("cont_two_scans", 32'(n_done - b_done), 32'd2);
    chk("cont_frames_2scans", 32'(n_convst - b_conv), 32'd5);
    continuous = 1'b0;
    wait_idle("cont_timeout");
    chk("cont_frames", 32'(n_convst - b_conv), 32'd7);
    chk("cont_busy_cycles", 32'(n_busy - b_busy), 32'(7 * FRAME));
    chk("cont_done", 32'(n_done - b_done), 32'd3);
    chk("cont_samples", 32'(n_samp - b_samp), 32'd6);
    for (int f = 0; f < 6; f++) begin
      if (cfg_log.size() > b_log + f)
        chk("cont_cfg_mux", 32'(cfg_log[b_log + f]),
            (f % 2 == 0) ? 32'b0100010 : 32'b1101010);
      else
        chk("cont_cfg_missing", 32'(cfg_log.size()), 32'(b_log + f + 1));
    end

    // Reset during SHIFT bit 5 of a frame, then a fresh scan.
    exp_q.push_back({4'd0, 12'hA5A});
    do_start(13'h0005, 1'b0);
    for (t = 0; t < 3000 && bitn < 6; t++) tick();
    tick();
    chk("pre_rst_sck_high", 32'(ADC_SCK), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_ctrl", {ADC_CONVST, ADC_SCK, ADC_SDI, MUX_CONTROL, busy, sample_valid,
                        scan_done, sample_ch}, 32'd0);
    chk("midrst_sample_data", 32'(sample_data), 32'd0);
    chk("midrst_ch_data", 32'(ch_data == '0), 32'd1);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    b_conv = n_convst; b_samp = n_samp;
    exp_q.push_back({4'd2, 12'h123});
    do_start(13'h0004, 1'b0);
    wait_idle("post_rst_timeout");
    chk("post_rst_frames", 32'(n_convst - b_conv), 32'd2);
    chk("post_rst_samples", 32'(n_samp - b_samp), 32'd1);
    chk("post_rst_ch0_clear", 32'(ch_data[0 +: DATA_W]), 32'h000);
    chk("post_rst_ch2", 32'(ch_data[2*DATA_W +: DATA_W]), 32'h123);
    chk("sdi_stable", 32'(glitch), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
